// File: rtl/hazard_fwd_ctrl.sv
// Hazard/forwarding control for the 5-stage RV32I pipeline.
// Define FORWARDING_EN for EX operand forwarding; otherwise hazards stall.
module hazard_fwd_ctrl #(
  parameter int REG_ADDR_W = 5,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_regwrite,
  input  logic                  id_memread,
  input  logic                  id_memwrite,
  input  logic                  branch_flush,
  input  logic                  mem_ready,
  output logic [1:0]            fwd_a_sel,
  output logic [1:0]            fwd_b_sel,
  output logic                  stall_if_id,
  output logic                  bubble_ex,
  output logic                  stall_all,
  output logic [CNT_W-1:0]      stall_cnt
);

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic                  use1;
    logic                  use2;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
  } ex_slot_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
    logic                  memread;
    logic                  memwrite;
  } mem_slot_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] rd;
    logic                  regwrite;
  } wb_slot_t;

  ex_slot_t   ex_q, ex_d;
  mem_slot_t  mem_q, mem_d;
  wb_slot_t   wb_q, wb_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic ex_wr, mem_wr;
  logic id_hit_ex, id_hit_mem;
  logic hazard, load_use;

  assign ex_wr  = ex_q.valid & ex_q.regwrite
                & (ex_q.rd != '0);
  assign mem_wr = mem_q.valid & mem_q.regwrite
                & (mem_q.rd != '0);

  assign id_hit_ex =
      (id_use_rs1 & (id_rs1 == ex_q.rd))
    | (id_use_rs2 & (id_rs2 == ex_q.rd));
  assign id_hit_mem =
      (id_use_rs1 & (id_rs1 == mem_q.rd))
    | (id_use_rs2 & (id_rs2 == mem_q.rd));

`ifdef FORWARDING_EN
  logic wb_wr;
  logic mem_a, mem_b, wb_a, wb_b;

  assign wb_wr = wb_q.valid & wb_q.regwrite
               & (wb_q.rd != '0);

  // Load data is not available from MEM, only once it reaches WB.
  assign mem_a = mem_wr & ~mem_q.memread & ex_q.use1
               & (mem_q.rd == ex_q.rs1);
  assign mem_b = mem_wr & ~mem_q.memread & ex_q.use2
               & (mem_q.rd == ex_q.rs2);
  assign wb_a  = wb_wr & ex_q.use1
               & (wb_q.rd == ex_q.rs1);
  assign wb_b  = wb_wr & ex_q.use2
               & (wb_q.rd == ex_q.rs2);

  always_comb begin
    fwd_a_sel = 2'b00;
    unique case (1'b1)
      mem_a:   fwd_a_sel = 2'b10;
      wb_a:    fwd_a_sel = 2'b01;
      default: fwd_a_sel = 2'b00;
    endcase
  end

  always_comb begin
    fwd_b_sel = 2'b00;
    unique case (1'b1)
      mem_b:   fwd_b_sel = 2'b10;
      wb_b:    fwd_b_sel = 2'b01;
      default: fwd_b_sel = 2'b00;
    endcase
  end

  assign hazard = ex_wr & ex_q.memread & id_hit_ex;
`else
  logic unused_fwd;

  assign fwd_a_sel = 2'b00;
  assign fwd_b_sel = 2'b00;

  // Producer must reach WB; regfile write-before-read covers it there.
  assign hazard = (ex_wr & id_hit_ex)
                | (mem_wr & id_hit_mem);

  assign unused_fwd = ^{wb_q, ex_q.rs1, ex_q.rs2,
                        ex_q.use1, ex_q.use2};
`endif

  assign stall_all = mem_q.valid & ~mem_ready
                   & (mem_q.memread | mem_q.memwrite);

  assign load_use = hazard & ~branch_flush & ~stall_all;

  assign stall_if_id = stall_all | load_use;
  assign bubble_ex   = load_use;
  assign stall_cnt   = cnt_q;

  always_comb begin
    ex_d  = ex_q;
    mem_d = mem_q;
    wb_d  = wb_q;
    if (!stall_all) begin
      wb_d = '{valid:    mem_q.valid,
               rd:       mem_q.rd,
               regwrite: mem_q.regwrite};
      mem_d = '{valid:    ex_q.valid,
                rd:       ex_q.rd,
                regwrite: ex_q.regwrite,
                memread:  ex_q.memread,
                memwrite: ex_q.memwrite};
      ex_d = '0;
      if (!(load_use | branch_flush)) begin
        ex_d = '{valid:    1'b1,
                 rs1:      id_rs1,
                 rs2:      id_rs2,
                 use1:     id_use_rs1,
                 use2:     id_use_rs2,
                 rd:       id_rd,
                 regwrite: id_regwrite,
                 memread:  id_memread,
                 memwrite: id_memwrite};
      end
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (stall_if_id && (cnt_q != '1)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_q  <= '0;
      mem_q <= '0;
      wb_q  <= '0;
      cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= mem_d;
      wb_q  <= wb_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl; follows FORWARDING_EN
// so the same vectors exercise the configuration being built.
module tb_hazard_fwd_ctrl;

  typedef struct packed {
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       u1;
    logic       u2;
    logic       rw;
    logic       mr;
    logic       bf;
    logic       rdy;
  } in_t;

  typedef struct packed {
    logic [1:0]  fa;
    logic [1:0]  fb;
    logic        sif;
    logic        bub;
    logic        sall;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic        id_use_rs1, id_use_rs2;
  logic        id_regwrite, id_memread, id_memwrite;
  logic        branch_flush, mem_ready;
  logic [1:0]  fwd_a_sel, fwd_b_sel;
  logic        stall_if_id, bubble_ex, stall_all;
  logic [15:0] stall_cnt;

  exp_t sb[$];
  int   tag_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_no = 0;

  hazard_fwd_ctrl #(.REG_ADDR_W(5), .CNT_W(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_use_rs1   (id_use_rs1),
    .id_use_rs2   (id_use_rs2),
    .id_rd        (id_rd),
    .id_regwrite  (id_regwrite),
    .id_memread   (id_memread),
    .id_memwrite  (id_memwrite),
    .branch_flush (branch_flush),
    .mem_ready    (mem_ready),
    .fwd_a_sel    (fwd_a_sel),
    .fwd_b_sel    (fwd_b_sel),
    .stall_if_id  (stall_if_id),
    .bubble_ex    (bubble_ex),
    .stall_all    (stall_all),
    .stall_cnt    (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic in_t mk(input int rd, input int rs1,
      input int rs2, input logic u1, input logic u2,
      input logic rw, input logic mr, input logic bf,
      input logic rdy);
    in_t x;
    x.rd = rd[4:0]; x.rs1 = rs1[4:0]; x.rs2 = rs2[4:0];
    x.u1 = u1; x.u2 = u2; x.rw = rw; x.mr = mr;
    x.bf = bf; x.rdy = rdy;
    return x;
  endfunction

  function automatic in_t nop();
    return mk(0, 0, 0, 0, 0, 0, 0, 0, 1);
  endfunction

  function automatic in_t alu(input int rd, input int a,
      input int b);
    return mk(rd, a, b, 1, 1, 1, 0, 0, 1);
  endfunction

  function automatic in_t ld(input int rd, input int a);
    return mk(rd, a, 0, 1, 0, 1, 1, 0, 1);
  endfunction

  function automatic in_t mod(input in_t x, input logic bf,
      input logic rdy);
    in_t y;
    y = x; y.bf = bf; y.rdy = rdy;
    return y;
  endfunction

  function automatic exp_t E(input int fa, input int fb,
      input logic sif, input logic bub, input logic sall,
      input int cnt);
    exp_t e;
    e.fa = fa[1:0]; e.fb = fb[1:0];
    e.sif = sif; e.bub = bub; e.sall = sall;
    e.cnt = cnt[15:0];
    return e;
  endfunction

  task automatic apply(input in_t x);
    id_rd        = x.rd;
    id_rs1       = x.rs1;
    id_rs2       = x.rs2;
    id_use_rs1   = x.u1;
    id_use_rs2   = x.u2;
    id_regwrite  = x.rw;
    id_memread   = x.mr;
    id_memwrite  = 1'b0;
    branch_flush = x.bf;
    mem_ready    = x.rdy;
  endtask

  task automatic push(input exp_t e);
    vec_no++;
    sb.push_back(e);
    tag_q.push_back(vec_no);
  endtask

  task automatic vec(input in_t x, input exp_t e);
    @(posedge clk);
    #1;
    apply(x);
    push(e);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    push(E(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    apply(nop());
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      int   t;
      e = sb.pop_front();
      t = tag_q.pop_front();
      checks++;
      if (fwd_a_sel !== e.fa || fwd_b_sel !== e.fb ||
          stall_if_id !== e.sif || bubble_ex !== e.bub ||
          stall_all !== e.sall || stall_cnt !== e.cnt) begin
        errors++;
        $display("FAIL vec%0d got fa=%b fb=%b sif=%b bub=%b sall=%b cnt=%0d want fa=%b fb=%b sif=%b bub=%b sall=%b cnt=%0d",
          t, fwd_a_sel, fwd_b_sel, stall_if_id, bubble_ex,
          stall_all, stall_cnt, e.fa, e.fb, e.sif, e.bub,
          e.sall, e.cnt);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    apply(nop());
    #3;
    push(E(0, 0, 0, 0, 0, 0));
    @(negedge clk);
    #1;
    rst_n = 1'b1;

`ifdef FORWARDING_EN
    vec(alu(5, 1, 2),  E(0, 0, 0, 0, 0, 0));
    vec(alu(8, 5, 3),  E(0, 0, 0, 0, 0, 0));
    vec(nop(),         E(2, 0, 0, 0, 0, 0));
    vec(alu(10, 1, 2), E(0, 0, 0, 0, 0, 0));
    vec(alu(11, 1, 2), E(0, 0, 0, 0, 0, 0));
    vec(alu(12, 10, 4), E(0, 0, 0, 0, 0, 0));
    vec(nop(),         E(1, 0, 0, 0, 0, 0));
    vec(alu(13, 1, 2), E(0, 0, 0, 0, 0, 0));
    vec(alu(13, 1, 2), E(0, 0, 0, 0, 0, 0));
    vec(alu(14, 13, 13), E(0, 0, 0, 0, 0, 0));
    vec(nop(),         E(2, 2, 0, 0, 0, 0));
    vec(ld(6, 1),      E(0, 0, 0, 0, 0, 0));
    vec(alu(15, 7, 6), E(0, 0, 1, 1, 0, 0));
    vec(alu(15, 7, 6), E(0, 0, 0, 0, 0, 1));
    vec(nop(),         E(0, 1, 0, 0, 0, 1));
`else
    vec(alu(7, 1, 2),  E(0, 0, 0, 0, 0, 0));
    vec(alu(8, 7, 3),  E(0, 0, 1, 1, 0, 0));
    vec(alu(8, 7, 3),  E(0, 0, 1, 1, 0, 1));
    vec(alu(8, 7, 3),  E(0, 0, 0, 0, 0, 2));
    vec(nop(),         E(0, 0, 0, 0, 0, 2));
    vec(alu(9, 1, 2),  E(0, 0, 0, 0, 0, 2));
    vec(mk(10, 2, 9, 1, 0, 1, 0, 0, 1),
                       E(0, 0, 0, 0, 0, 2));
    vec(nop(),         E(0, 0, 0, 0, 0, 2));
    vec(ld(11, 1),     E(0, 0, 0, 0, 0, 2));
    vec(alu(12, 3, 11), E(0, 0, 1, 1, 0, 2));
    vec(alu(12, 3, 11), E(0, 0, 1, 1, 0, 3));
    vec(alu(12, 3, 11), E(0, 0, 0, 0, 0, 4));
    vec(nop(),         E(0, 0, 0, 0, 0, 4));
`endif

    do_reset();

    // x0 writers never forward or stall
    vec(ld(0, 1),      E(0, 0, 0, 0, 0, 0));
    vec(alu(0, 1, 2),  E(0, 0, 0, 0, 0, 0));
    vec(alu(16, 0, 0), E(0, 0, 0, 0, 0, 0));
    vec(nop(),         E(0, 0, 0, 0, 0, 0));
    // three-cycle memory wait
    vec(ld(17, 1),     E(0, 0, 0, 0, 0, 0));
    vec(nop(),         E(0, 0, 0, 0, 0, 0));
    vec(mod(alu(18, 2, 3), 0, 0), E(0, 0, 1, 0, 1, 0));
    vec(mod(alu(18, 2, 3), 0, 0), E(0, 0, 1, 0, 1, 1));
    vec(mod(alu(18, 2, 3), 0, 0), E(0, 0, 1, 0, 1, 2));
    vec(alu(18, 2, 3), E(0, 0, 0, 0, 0, 3));
    vec(nop(),         E(0, 0, 0, 0, 0, 3));
    // flush suppresses load-use and kills the ID instruction
    vec(ld(19, 1),     E(0, 0, 0, 0, 0, 3));
    vec(mk(20, 19, 0, 1, 0, 1, 0, 1, 1),
                       E(0, 0, 0, 0, 0, 3));
    vec(mk(22, 20, 0, 1, 0, 1, 0, 0, 1),
                       E(0, 0, 0, 0, 0, 3));
    vec(nop(),         E(0, 0, 0, 0, 0, 3));
    // load-use + flush + memory wait together
    vec(ld(23, 1),     E(0, 0, 0, 0, 0, 3));
    vec(ld(24, 1),     E(0, 0, 0, 0, 0, 3));
    vec(mk(25, 24, 0, 1, 0, 1, 0, 1, 0),
                       E(0, 0, 1, 0, 1, 3));
    vec(mk(25, 24, 0, 1, 0, 1, 0, 1, 1),
                       E(0, 0, 0, 0, 0, 4));
    vec(nop(),         E(0, 0, 0, 0, 0, 4));
    // reset in the middle of a memory stall
    vec(ld(26, 1),     E(0, 0, 0, 0, 0, 4));
    vec(nop(),         E(0, 0, 0, 0, 0, 4));
    vec(mod(nop(), 0, 0), E(0, 0, 1, 0, 1, 4));
    vec(mod(nop(), 0, 0), E(0, 0, 1, 0, 1, 5));
    do_reset();

    for (int k = 0; k < 20 && sb.size() > 0; k++) begin
      @(negedge clk);
      #1;
    end
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_fwd_ctrl.md
# hazard_fwd_ctrl

Pipeline hazard and forwarding controller for the 5-stage RV32I core. It tracks the destination-register metadata of the instructions in EX, MEM and WB. From that it drives the select inputs of the two EX-stage 3:1 operand muxes (A and B), inserts load-use bubbles, and freezes the pipeline while data memory is not ready. It keeps per-stage slot registers internally and a saturating stall-cycle counter. It sits beside the ID/EX pipeline register and is the only driver of operand-mux selects and pipeline stall/bubble controls.

## Interface
- REG_ADDR_W, 5, register-index width
- CNT_W, 16, stall counter width
- clk  in  1  core clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- id_rs1, id_rs2  in  REG_ADDR_W  source registers of the instruction in ID
- id_use_rs1, id_use_rs2  in  1  ID instruction actually reads rs1/rs2
- id_rd  in  REG_ADDR_W  destination of the ID instruction
- id_regwrite, id_memread, id_memwrite  in  1  ID instruction control
- branch_flush  in  1  taken branch/jump resolved in EX; discard the ID instruction
- mem_ready  in  1  data memory completes the MEM-stage access this cycle
- fwd_a_sel, fwd_b_sel  out  2  operand mux selects: 00 regfile, 01 WB result, 10 MEM ALU result
- stall_if_id  out  1  hold PC and IF/ID register
- bubble_ex  out  1  load NOP into ID/EX
- stall_all  out  1  freeze every pipeline register
- stall_cnt  out  CNT_W  saturating count of cycles with any stall/bubble asserted

## Operation
- Slots: EX {valid, rs1, rs2, use1, use2, rd, regwrite, memread, memwrite}; MEM {valid, rd, regwrite, memread, memwrite}; WB {valid, rd, regwrite}.
- A slot is a "writer" when it has valid & regwrite & rd != 0. x0 is never a hazard or forward source.
- fwd_a_sel:
  - 10 if the MEM slot is a writer, is not a load, and MEM.rd == EX.rs1 & EX.use1.
  - Otherwise 01 if the WB slot is a writer and WB.rd == EX.rs1 & EX.use1.
  - Otherwise 00.
  - MEM has priority over WB. fwd_b_sel is identical using rs2/use2.
- Load-use: the EX slot is a writer with memread, and EX.rd matches an ID source that is used. Result: stall_if_id = 1 and bubble_ex = 1 for that cycle.
- Mem wait: stall_all = MEM.valid & (MEM.memread | MEM.memwrite) & !mem_ready.
- branch_flush: the ID instruction enters EX as a bubble, and load-use detection is suppressed.
- Advance, on a rising edge when stall_all = 0:
  - WB <= MEM and MEM <= EX.
  - EX <= bubble (valid = 0) if bubble_ex or branch_flush; otherwise EX <= ID fields with valid = 1.
- When stall_all = 1:
  - No slot changes.
  - stall_if_id = 1, bubble_ex = 0, and load-use is masked; stall_all dominates.
  - branch_flush is ignored; the branch unit holds it until the stall clears.
- The regfile performs write-before-read. This block never forwards into ID.
- stall_cnt increments by 1 on each edge where stall_if_id | stall_all was 1. It holds at all-ones.

## Timing
- Reset, asynchronous: all slots invalid; fwd_*_sel = 00; stall_if_id = bubble_ex = stall_all = 0; stall_cnt = 0. The first rising edge after rst_n deasserts is a normal advance.
- All outputs are combinational from slot registers and the current inputs. There is zero-cycle latency from inputs to stall/bubble.
- Load-use costs exactly one bubble. On the next cycle the load is in MEM and the consumer is still in ID. One cycle later the load is in WB, the consumer is in EX, and sel = 01.
- MEM wait of N cycles with mem_ready low gives exactly N cycles of stall_all = 1. fwd selects are constant throughout.
- If load-use, branch_flush and mem_ready low all occur in one cycle, stall_all wins. The load-use and branch_flush conditions are re-evaluated after release.
- Reset asserted mid-stall clears everything immediately, with no dependence on clk.

## Configuration
- FORWARDING_EN defined: behaviour as above.
- FORWARDING_EN undefined:
  - fwd_a_sel and fwd_b_sel are tied to 00.
  - stall_if_id = bubble_ex = 1 whenever a used ID source matches the rd of an EX or MEM writer, load or not.
  - The bubble repeats each cycle until the producer reaches WB.
  - Mem-wait behaviour is unchanged.

## Test plan
- add x5 followed directly by sub using x5 as rs1 -> consumer in EX has fwd_a_sel = 10. Insert one unrelated instruction between them -> fwd_a_sel = 01.
- lw x6 followed directly by add using x6 as rs2 -> stall_if_id = bubble_ex = 1 for one cycle; consumer later sees fwd_b_sel = 01; stall_cnt = 1.
- Writers to x0 in MEM and WB with a consumer reading x0 -> sels 00, no stall.
- lw in MEM with mem_ready low for 3 cycles -> stall_all = 1 for exactly 3 cycles, slots frozen, stall_cnt = 3.
- Load-use coinciding with branch_flush -> no bubble, EX gets an invalid slot; again with mem_ready low -> stall_all only.
- FORWARDING_EN undefined, add x7 then a consumer of x7 -> 2 bubble cycles, sels always 00. Assert rst_n low mid-stall -> all outputs zero immediately.
